led_sequencer: RTL and testbench

Pattern controller for the board's 3-bit LED bank on the 24 MHz Tang Primer clock. It divides the clock to a programmable step rate and sequences `out0[2:0]` through one of four patterns. The pattern is selected at run time through a req/ack handshake. It sits between the top-level control logic and the LED pins, replacing ad-hoc free-running counters.

---
 rtl/led_sequencer_if.sv | 9 +
 rtl/led_sequencer.sv | 87 ++++++++
 tb/tb_led_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: mode-select req/ack handshake between control logic and the LED sequencer
interface led_sequencer_if;
  logic       mode_req;
  logic [1:0] mode_in;
  logic       mode_ack;
  logic [1:0] mode;
  modport master(output mode_req, mode_in, input mode_ack, mode);
  modport slave(input mode_req, mode_in, output mode_ack, mode);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: prescaled 3-bit LED pattern generator with req/ack mode select
// Optional PWM dimming via duty input when LED_SEQ_PWM_EN is defined.
module led_sequencer #(
  parameter int DIV = 12_000_000,
  parameter int CW  = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  led_sequencer_if.slave   ms,
  output logic             tick,
  output logic [2:0]       out0
`ifdef LED_SEQ_PWM_EN
  ,
  input  logic [7:0]       duty
`endif
);
  typedef enum logic [1:0] {COUNT, ROTATE, BOUNCE, OFF} mode_t;
  mode_t         mode_q, mode_d, mi;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pat_q, pat_d, out0_q, out0_d;
  logic          dir_q, dir_d, tick_q, tick_d, ack_q, ack_d, seen_q, seen_d;
  logic          load, wrap;
`ifdef LED_SEQ_PWM_EN
  logic [7:0]    pwm_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) pwm_q <= '0;
    else pwm_q <= pwm_q + 8'd1;
`endif
  always_comb begin
    mi     = mode_t'(ms.mode_in);
    load   = ms.mode_req & ~ack_q & ~seen_q;
    wrap   = run & (cnt_q == CW'(DIV - 1));
    // seen blocks re-acceptance until mode_req has dropped at least once
    seen_d = ms.mode_req & (seen_q | load);
    ack_d  = load;
    tick_d = wrap & ~load;
    cnt_d  = (load | wrap) ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    mode_d = load ? mi : mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    if (load) begin
      pat_d = (mi == ROTATE || mi == BOUNCE) ? 3'b001 : 3'b000;
      dir_d = 1'b1;
    end else if (tick_d) begin
      case (mode_q)
        COUNT:   pat_d = pat_q + 3'd1;
        ROTATE:  pat_d = {pat_q[1:0], pat_q[2]};
        BOUNCE: begin
          pat_d = dir_q ? (pat_q == 3'b100 ? 3'b010 : pat_q << 1)
                        : (pat_q == 3'b001 ? 3'b010 : pat_q >> 1);
          dir_d = dir_q ? (pat_q != 3'b100) : (pat_q == 3'b001);
        end
        default: pat_d = 3'b000;
      endcase
    end
`ifdef LED_SEQ_PWM_EN
    out0_d = pat_q & {3{pwm_q < duty}};
`else
    out0_d = pat_q;
`endif
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mode_q <= COUNT;
      cnt_q  <= '0;
      pat_q  <= '0;
      dir_q  <= 1'b1;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      seen_q <= 1'b0;
      out0_q <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      seen_q <= seen_d;
      out0_q <= out0_d;
    end
  assign ms.mode_ack = ack_q;
  assign ms.mode     = mode_q;
  assign tick        = tick_q;
  assign out0        = out0_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer with DIV=4
module tb_led_sequencer;
  logic       clock = 1'b0;
  logic       reset, run, tick;
  logic [2:0] out0;
  int         errors = 0, checks = 0, acks, on;
`ifdef LED_SEQ_PWM_EN
  logic [7:0] duty;
`endif
  led_sequencer_if bus();
  led_sequencer #(.DIV(4), .CW(3)) dut (
    .clock(clock), .reset(reset), .run(run), .ms(bus), .tick(tick), .out0(out0)
`ifdef LED_SEQ_PWM_EN
    , .duty(duty)
`endif
  );
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    reset = 1'b1; run = 1'b1; bus.mode_req = 1'b0; bus.mode_in = 2'd0;
`ifdef LED_SEQ_PWM_EN
    duty = 8'd255;
`endif
    cyc(3);
    check("rst_out0", out0, 0);
    check("rst_tick", tick, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_ack", bus.mode_ack, 0);
    reset = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cyc(1);
      check("cnt_tick", tick, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 1 && k > 1) check("cnt_out0", out0, ((k - 1) / 4) % 8);
    end
    bus.mode_in = 2'd1; bus.mode_req = 1'b1;
    cyc(1);
    check("rot_ack", bus.mode_ack, 1);
    check("rot_mode", bus.mode, 1);
    check("rot_tick", tick, 0);
    bus.mode_req = 1'b0;
    cyc(1);
    check("rot_init", out0, 3'b001);
    check("rot_ack_low", bus.mode_ack, 0);
    cyc(3); check("rot_tick1", tick, 1);
    cyc(1); check("rot_s1", out0, 3'b010);
    cyc(4); check("rot_s2", out0, 3'b100);
    cyc(4); check("rot_s3", out0, 3'b001);
    bus.mode_in = 2'd2; bus.mode_req = 1'b1;
    cyc(1);
    check("bnc_ack", bus.mode_ack, 1);
    check("bnc_mode", bus.mode, 2);
    bus.mode_req = 1'b0;
    cyc(1); check("bnc_init", out0, 3'b001);
    cyc(4); check("bnc_s1", out0, 3'b010);
    cyc(4); check("bnc_s2", out0, 3'b100);
    run = 1'b0;
    repeat (10) begin
      cyc(1);
      check("hold_out0", out0, 3'b100);
      check("hold_tick", tick, 0);
    end
    run = 1'b1;
    cyc(3); check("resume_tick", tick, 1);
    cyc(1); check("bnc_s3", out0, 3'b010);
    cyc(4); check("bnc_s4", out0, 3'b001);
    cyc(4); check("bnc_s5", out0, 3'b010);
    cyc(2);
    bus.mode_in = 2'd1; bus.mode_req = 1'b1;
    cyc(1);
    check("col_ack", bus.mode_ack, 1);
    check("col_tick", tick, 0);
    check("col_mode", bus.mode, 1);
    bus.mode_req = 1'b0;
    cyc(1); check("col_init", out0, 3'b001);
    cyc(2); check("col_notick", tick, 0);
    cyc(1); check("col_tick4", tick, 1);
    cyc(1); check("col_s1", out0, 3'b010);
    bus.mode_in = 2'd2; bus.mode_req = 1'b1;
    acks = 0;
    repeat (5) begin
      cyc(1);
      acks += int'(bus.mode_ack);
    end
    check("held_acks", acks, 1);
    check("held_mode", bus.mode, 2);
    bus.mode_req = 1'b0;
    cyc(1);
    check("held_ack_low", bus.mode_ack, 0);
    check("held_out0", out0, 3'b010);
    #2 reset = 1'b1;
    #1;
    check("arst_out0", out0, 0);
    check("arst_mode", bus.mode, 0);
    check("arst_tick", tick, 0);
    cyc(1);
    reset = 1'b0;
    cyc(3); check("rel_notick", tick, 0);
    cyc(1);
    check("rel_tick", tick, 1);
    check("rel_mode", bus.mode, 0);
    cyc(1); check("rel_out0", out0, 3'b001);
`ifdef LED_SEQ_PWM_EN
    run = 1'b0; duty = 8'd64; on = 0;
    repeat (256) begin
      cyc(1);
      on += (out0 != 3'b000) ? 1 : 0;
    end
    check("pwm_64", on, 64);
    duty = 8'd0; on = 0;
    repeat (256) begin
      cyc(1);
      on += (out0 != 3'b000) ? 1 : 0;
    end
    check("pwm_0", on, 0);
`else
    on = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
